// File: rtl/vrf_elem_sequencer_pkg.sv
// Shared types for the element-serial vector sequencer: ALU opcodes and FSM states.
package vec_seq_pkg;

    // Codes 6 and 7 both copy vs1 (MV).
    typedef enum logic [2:0] {
        OP_ADD    = 3'd0,
        OP_SUB    = 3'd1,
        OP_AND    = 3'd2,
        OP_OR     = 3'd3,
        OP_XOR    = 3'd4,
        OP_MAX    = 3'd5,
        OP_MV     = 3'd6,
        OP_MV_ALT = 3'd7
    } vec_op_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } seq_state_e;

endpackage

// File: rtl/vrf_elem_sequencer_if.sv
// Command handshake plus register-file read/write ports of the vector sequencer.
interface vrf_elem_sequencer_if #(
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned DATA_WIDTH = 32
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [2:0]            cmd_op;
    logic [ADDR_WIDTH-1:0] cmd_vd;
    logic [ADDR_WIDTH-1:0] cmd_vs1;
    logic [ADDR_WIDTH-1:0] cmd_vs2;
    logic [ADDR_WIDTH:0]   cmd_vl;

    logic [ADDR_WIDTH-1:0] rAddr1_1;
    logic [ADDR_WIDTH-1:0] rAddr2_1;
    logic [DATA_WIDTH-1:0] rData1;
    logic [ADDR_WIDTH-1:0] rAddr1_2;
    logic [ADDR_WIDTH-1:0] rAddr2_2;
    logic [DATA_WIDTH-1:0] rData2;

    logic [ADDR_WIDTH-1:0] wAddr1;
    logic [ADDR_WIDTH-1:0] wAddr2;
    logic [DATA_WIDTH-1:0] wData;
    logic                  wEnable;

    // Sequencer side: accepts commands, initiates register-file traffic.
    modport master (
        input  cmd_valid, cmd_op, cmd_vd, cmd_vs1, cmd_vs2, cmd_vl, rData1, rData2,
        output cmd_ready, rAddr1_1, rAddr2_1, rAddr1_2, rAddr2_2,
               wAddr1, wAddr2, wData, wEnable
    );

    // Decoder / register-file side.
    modport slave (
        output cmd_valid, cmd_op, cmd_vd, cmd_vs1, cmd_vs2, cmd_vl, rData1, rData2,
        input  cmd_ready, rAddr1_1, rAddr2_1, rAddr1_2, rAddr2_2,
               wAddr1, wAddr2, wData, wEnable
    );

endinterface

// File: rtl/vrf_elem_sequencer_alu.sv
// Combinational per-element ALU; results wrap, MAX is signed, MV forwards operand a.
module vec_alu_elem
    import vec_seq_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  vec_op_e               op,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic [DATA_WIDTH-1:0] y
);

    always_comb begin
        y = a;
        case (op)
            OP_ADD:  y = a + b;
            OP_SUB:  y = a - b;
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_XOR:  y = a ^ b;
            OP_MAX:  y = ($signed(a) > $signed(b)) ? a : b;
            default: y = a;
        endcase
    end

endmodule

// File: rtl/vrf_elem_sequencer.sv
// Element-serial vector sequencer: latches one command, reads vs1/vs2 per element,
// writes vd one cycle later through a registered write stage.
module vrf_elem_sequencer
    import vec_seq_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned NUM_REG    = 6,
    parameter int unsigned NUM_ELE    = 32
) (
    input  logic                 clk,
    input  logic                 reset_n,
    vrf_elem_sequencer_if.master bus,
    output logic                 busy,
    output logic                 done
);

    if ((NUM_REG > (1 << ADDR_WIDTH)) || (NUM_ELE > (1 << ADDR_WIDTH))) begin : g_param_check
        $error("NUM_REG/NUM_ELE do not fit in ADDR_WIDTH");
    end

    localparam logic [ADDR_WIDTH:0] VL_MAX = (ADDR_WIDTH + 1)'(NUM_ELE);

    seq_state_e            state;
    seq_state_e            state_nxt;
    logic [ADDR_WIDTH-1:0] idx;
    logic [ADDR_WIDTH-1:0] vd_q;
    logic [ADDR_WIDTH-1:0] vs1_q;
    logic [ADDR_WIDTH-1:0] vs2_q;
    logic [ADDR_WIDTH:0]   vl_q;
    vec_op_e               op_q;

    logic                  accept;
    logic                  last_elem;
    logic [ADDR_WIDTH:0]   vl_clamped;
    logic [DATA_WIDTH-1:0] alu_y;

    logic                  w_en_q;
    logic [ADDR_WIDTH-1:0] w_addr1_q;
    logic [ADDR_WIDTH-1:0] w_addr2_q;
    logic [DATA_WIDTH-1:0] w_data_q;

    assign accept     = bus.cmd_valid && (state == S_IDLE);
    assign vl_clamped = (bus.cmd_vl > VL_MAX) ? VL_MAX : bus.cmd_vl;
    assign last_elem  = ({1'b0, idx} == (vl_q - 1'b1));

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (accept) state_nxt = (vl_clamped == '0) ? S_DRAIN : S_RUN;
            S_RUN:   if (last_elem) state_nxt = S_DRAIN;
            S_DRAIN: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // idx parks on the last element; the next accept rewinds it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            idx   <= '0;
            vd_q  <= '0;
            vs1_q <= '0;
            vs2_q <= '0;
            vl_q  <= '0;
            op_q  <= OP_ADD;
        end else if (accept) begin
            idx   <= '0;
            vd_q  <= bus.cmd_vd;
            vs1_q <= bus.cmd_vs1;
            vs2_q <= bus.cmd_vs2;
            vl_q  <= vl_clamped;
            op_q  <= vec_op_e'(bus.cmd_op);
        end else if ((state == S_RUN) && !last_elem) begin
            idx <= idx + 1'b1;
        end
    end

    vec_alu_elem #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_alu (
        .op(op_q),
        .a (bus.rData1),
        .b (bus.rData2),
        .y (alu_y)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            w_en_q    <= 1'b0;
            w_addr1_q <= '0;
            w_addr2_q <= '0;
            w_data_q  <= '0;
        end else if (state == S_RUN) begin
            w_en_q    <= 1'b1;
            w_addr1_q <= vd_q;
            w_addr2_q <= idx;
            w_data_q  <= alu_y;
        end else begin
            w_en_q    <= 1'b0;
            w_addr1_q <= '0;
            w_addr2_q <= '0;
            w_data_q  <= '0;
        end
    end

    assign bus.rAddr1_1  = (state == S_RUN) ? vs1_q : '0;
    assign bus.rAddr2_1  = (state == S_RUN) ? idx   : '0;
    assign bus.rAddr1_2  = (state == S_RUN) ? vs2_q : '0;
    assign bus.rAddr2_2  = (state == S_RUN) ? idx   : '0;

    assign bus.wEnable   = w_en_q;
    assign bus.wAddr1    = w_addr1_q;
    assign bus.wAddr2    = w_addr2_q;
    assign bus.wData     = w_data_q;

    assign bus.cmd_ready = (state == S_IDLE);
    assign busy          = (state != S_IDLE);
    assign done          = (state == S_DRAIN);

endmodule

// File: tb/tb_vrf_elem_sequencer.sv
// Scoreboard bench for vrf_elem_sequencer with a behavioural 6x32 register file.
module tb_vrf_elem_sequencer;

    logic clk = 1'b0;
    logic reset_n;
    logic busy;
    logic done;

    always #5 clk = ~clk;

    vrf_elem_sequencer_if #(.ADDR_WIDTH(5), .DATA_WIDTH(32)) bus ();

    vrf_elem_sequencer #(
        .ADDR_WIDTH(5),
        .DATA_WIDTH(32),
        .NUM_REG   (6),
        .NUM_ELE   (32)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus),
        .busy   (busy),
        .done   (done)
    );

    typedef struct {
        int          cyc;
        logic [4:0]  a1;
        logic [4:0]  a2;
        logic [31:0] d;
    } wr_t;

    logic [31:0] rf   [6][32];
    bit          mark [6][32];
    logic        poke_en = 1'b0;
    int          poke_reg = 0;
    logic [31:0] poke_vals [32];
    logic [31:0] exp_data  [32];
    int          cyc = 0;

    wr_t wq[$];
    int  dq[$];
    int  checks = 0;
    int  failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Register-file model: combinational reads, commit on the rising edge.
    assign bus.rData1 = (bus.rAddr1_1 < 5'd6) ? rf[bus.rAddr1_1][bus.rAddr2_1] : 32'h0;
    assign bus.rData2 = (bus.rAddr1_2 < 5'd6) ? rf[bus.rAddr1_2][bus.rAddr2_2] : 32'h0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (poke_en)
            for (int i = 0; i < 32; i++) rf[poke_reg][i] <= poke_vals[i];
        if (bus.cmd_valid && bus.cmd_ready)
            for (int r = 0; r < 6; r++)
                for (int e = 0; e < 32; e++) mark[r][e] <= 1'b0;
        if (bus.wEnable && (bus.wAddr1 < 5'd6)) begin
            rf[bus.wAddr1][bus.wAddr2]   <= bus.wData;
            mark[bus.wAddr1][bus.wAddr2] <= 1'b1;
        end
    end

    // Monitor: pops expected writes / done pulses as the DUT presents them.
    always @(negedge clk) begin
        wr_t e;
        int  dc;
        if (reset_n === 1'b1) begin
            if (bus.wEnable) begin
                if (wq.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_write actual=%0h:%0h required=none", bus.wAddr1, bus.wAddr2);
                end else begin
                    e = wq.pop_front();
                    chk("wr_cycle", 64'(cyc), 64'(e.cyc));
                    chk("wr_addr", {bus.wAddr1, bus.wAddr2}, {e.a1, e.a2});
                    chk("wr_data", bus.wData, e.d);
                end
            end
            if (done) begin
                if (dq.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_done actual=%0d required=none", cyc);
                end else begin
                    dc = dq.pop_front();
                    chk("done_cycle", 64'(cyc), 64'(dc));
                end
            end
            if (busy && !done) begin
                chk("raw_hazard",
                    (bus.rAddr1_1 < 5'd6) ? 64'(mark[bus.rAddr1_1][bus.rAddr2_1]) : 64'd0, 64'd0);
            end else begin
                chk("idle_raddr", {bus.rAddr1_1, bus.rAddr2_1, bus.rAddr1_2, bus.rAddr2_2}, 64'd0);
            end
        end
    end

    task automatic do_poke(input int r);
        poke_reg = r;
        poke_en  = 1'b1;
        @(negedge clk);
        poke_en  = 1'b0;
    endtask

    task automatic issue(input logic [2:0] op, input logic [4:0] vd, input logic [4:0] vs1,
                         input logic [4:0] vs2, input logic [5:0] vl, input int n_wr,
                         input bit want_done, output int c0);
        int t = 0;
        int vl_eff;
        bus.cmd_op    = op;
        bus.cmd_vd    = vd;
        bus.cmd_vs1   = vs1;
        bus.cmd_vs2   = vs2;
        bus.cmd_vl    = vl;
        bus.cmd_valid = 1'b1;
        while (!bus.cmd_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (!bus.cmd_ready) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout actual=not_ready required=ready");
            c0 = -1;
            return;
        end
        c0 = cyc + 1;
        vl_eff = (vl > 6'd32) ? 32 : int'(vl);
        for (int i = 0; i < n_wr; i++)
            wq.push_back('{cyc: c0 + i + 1, a1: vd, a2: 5'(i), d: exp_data[i]});
        if (want_done) dq.push_back(c0 + vl_eff);
        @(negedge clk);
    endtask

    task automatic wait_idle();
        int t = 0;
        while (!bus.cmd_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!bus.cmd_ready) begin
            checks++;
            failures++;
            $display("FAIL idle_timeout actual=busy required=idle");
        end
        @(negedge clk);
    endtask

    task automatic check_reset_outs();
        chk("rst_ctrl", {bus.cmd_ready, busy, done, bus.wEnable}, 64'b1000);
        chk("rst_addr", {bus.wAddr1, bus.wAddr2, bus.rAddr1_1, bus.rAddr2_1,
                         bus.rAddr1_2, bus.rAddr2_2}, 64'd0);
        chk("rst_wdata", bus.wData, 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        int c0b;
        int nz;

        reset_n       = 1'b0;
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = 3'd0;
        bus.cmd_vd    = 5'd2;
        bus.cmd_vs1   = 5'd0;
        bus.cmd_vs2   = 5'd1;
        bus.cmd_vl    = 6'd4;
        @(negedge clk);
        for (int i = 0; i < 32; i++) poke_vals[i] = 32'(i);
        do_poke(0);
        for (int i = 0; i < 32; i++) poke_vals[i] = 32'd10;
        do_poke(1);
        check_reset_outs();

        // ADD v2 = v0 + v1, vl=4 -> 10,11,12,13
        reset_n = 1'b1;
        exp_data[0] = 32'd10; exp_data[1] = 32'd11; exp_data[2] = 32'd12; exp_data[3] = 32'd13;
        issue(3'd0, 5'd2, 5'd0, 5'd1, 6'd4, 4, 1'b1, c0);
        bus.cmd_valid = 1'b0;
        wait_idle();
        for (int i = 0; i < 4; i++) chk("add_file", rf[2][i], 64'(10 + i));

        // SUB 0 - 1 wraps
        for (int i = 0; i < 32; i++) poke_vals[i] = 32'd1;
        do_poke(1);
        exp_data[0] = 32'hFFFF_FFFF;
        issue(3'd1, 5'd4, 5'd0, 5'd1, 6'd1, 1, 1'b1, c0);
        bus.cmd_valid = 1'b0;
        wait_idle();

        // MAX(-1, 1) = 1 under signed compare
        exp_data[0] = 32'd1;
        issue(3'd5, 5'd5, 5'd4, 5'd1, 6'd1, 1, 1'b1, c0);
        bus.cmd_valid = 1'b0;
        wait_idle();

        // OR with 8, AND with 2, MAX against most-negative value
        for (int i = 0; i < 32; i++) poke_vals[i] = 32'd8;
        do_poke(1);
        exp_data[0] = 32'd8; exp_data[1] = 32'd9; exp_data[2] = 32'd10; exp_data[3] = 32'd11;
        issue(3'd3, 5'd4, 5'd0, 5'd1, 6'd4, 4, 1'b1, c0);
        bus.cmd_valid = 1'b0;
        wait_idle();
        for (int i = 0; i < 32; i++) poke_vals[i] = 32'd2;
        do_poke(1);
        exp_data[0] = 32'd0; exp_data[1] = 32'd0; exp_data[2] = 32'd2; exp_data[3] = 32'd2;
        issue(3'd2, 5'd4, 5'd0, 5'd1, 6'd4, 4, 1'b1, c0);
        bus.cmd_valid = 1'b0;
        wait_idle();
        for (int i = 0; i < 32; i++) poke_vals[i] = 32'h8000_0000;
        do_poke(1);
        exp_data[0] = 32'd0; exp_data[1] = 32'd1;
        issue(3'd5, 5'd4, 5'd0, 5'd1, 6'd2, 2, 1'b1, c0);
        bus.cmd_valid = 1'b0;
        wait_idle();

        // vl=0: done in cycle 0, no writes
        issue(3'd0, 5'd5, 5'd0, 5'd1, 6'd0, 0, 1'b1, c0);
        bus.cmd_valid = 1'b0;
        wait_idle();

        // vl=40 clamps to 32; op 7 is MV
        for (int i = 0; i < 32; i++) exp_data[i] = 32'(i);
        issue(3'd7, 5'd5, 5'd0, 5'd1, 6'd40, 32, 1'b1, c0);
        bus.cmd_valid = 1'b0;
        wait_idle();

        // In-place XOR v3 = v3 ^ v3
        for (int i = 0; i < 32; i++) poke_vals[i] = 32'hA5A5_0000 ^ 32'(i);
        do_poke(3);
        for (int i = 0; i < 32; i++) exp_data[i] = 32'd0;
        issue(3'd4, 5'd3, 5'd3, 5'd3, 6'd32, 32, 1'b1, c0);
        bus.cmd_valid = 1'b0;
        wait_idle();
        nz = 0;
        for (int i = 0; i < 32; i++) if (rf[3][i] != 32'd0) nz++;
        chk("xor_inplace_nonzero", 64'(nz), 64'd0);

        // Reset mid-command after 5 commits; element 5 is presented but must not commit
        for (int i = 0; i < 32; i++) poke_vals[i] = 32'd100;
        do_poke(1);
        for (int i = 0; i < 32; i++) poke_vals[i] = 32'hDEAD_0000 + 32'(i);
        do_poke(5);
        for (int i = 0; i < 6; i++) exp_data[i] = 32'(100 + i);
        issue(3'd0, 5'd5, 5'd0, 5'd1, 6'd16, 6, 1'b0, c0);
        bus.cmd_valid = 1'b0;
        while (cyc < c0 + 6) @(negedge clk);
        #2 reset_n = 1'b0;
        #1 check_reset_outs();
        chk("abort_queue", 64'(wq.size() + dq.size()), 64'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 16; i++)
            chk("abort_file", rf[5][i], (i < 5) ? 64'(100 + i) : 64'(32'hDEAD_0000 + i));
        exp_data[0] = 32'd100; exp_data[1] = 32'd101;
        issue(3'd0, 5'd2, 5'd0, 5'd1, 6'd2, 2, 1'b1, c0);
        bus.cmd_valid = 1'b0;
        wait_idle();

        // Back-to-back with cmd_valid held; garbage fields while busy
        exp_data[0] = 32'd100; exp_data[1] = 32'd99; exp_data[2] = 32'd98;
        issue(3'd1, 5'd2, 5'd1, 5'd0, 6'd3, 3, 1'b1, c0);
        for (int t = 0; t < 50 && !bus.cmd_ready; t++) begin
            bus.cmd_op  = 3'($urandom);
            bus.cmd_vd  = 5'd1;
            bus.cmd_vs1 = 5'($urandom_range(0, 5));
            bus.cmd_vs2 = 5'($urandom_range(0, 5));
            bus.cmd_vl  = 6'($urandom_range(1, 40));
            @(negedge clk);
        end
        exp_data[0] = 32'd100; exp_data[1] = 32'd101;
        issue(3'd4, 5'd4, 5'd0, 5'd1, 6'd2, 2, 1'b1, c0b);
        bus.cmd_valid = 1'b0;
        chk("b2b_gap", 64'(c0b - c0), 64'd5);
        wait_idle();

        repeat (3) @(negedge clk);
        chk("queues_drained", 64'(wq.size() + dq.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
